// File: rtl/axis_i2s_tx.sv
// ============================================================================
// axis_i2s_tx
// ----------------------------------------------------------------------------
// Purpose:
//   Takes stereo samples from the audio formatter's MM2S AXI-Stream and
//   serialises them onto a Philips I2S transmit port. Left/right beats are
//   paired into a one-frame buffer. The buffer is moved into the output shift
//   register once per 64-BCLK frame. The block flags underruns, where no
//   complete pair is ready at frame load, and channel-sync errors, where an
//   unexpected tid is accepted. BCLK and LRCLK come from the single system
//   clock.
//
// Ports:
//   s_axis_aud_aclk     in   clock for all logic
//   s_axis_aud_aresetn  in   asynchronous active-low reset
//   s_axis_aud_tvalid   in   stream beat valid
//   s_axis_aud_tready   out  stream ready (low while a full pair is waiting)
//   s_axis_aud_tdata    in   [31:0] sample word, 24-bit sample in [27:4]
//   s_axis_aud_tid      in   [7:0] channel id: 0 = left, 1 = right
//   en                  in   transmit enable (synchronous stop when low)
//   i2s_bclk            out  bit clock, clk / (2*BCLK_DIV)
//   i2s_lrclk           out  word select, 0 = left
//   i2s_sdata           out  serial data, MSB first, one BCLK after LRCLK edge
//   underrun            out  one-cycle pulse: frame loaded without a pair
//   sync_err            out  one-cycle pulse: unexpected tid accepted
//   underrun_cnt        out  [CNT_W-1:0] saturating underrun count
// ============================================================================
module axis_i2s_tx #(
    parameter int BCLK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic             s_axis_aud_aclk,
    input  logic             s_axis_aud_aresetn,
    input  logic             s_axis_aud_tvalid,
    output logic             s_axis_aud_tready,
    input  logic [31:0]      s_axis_aud_tdata,
    input  logic [7:0]       s_axis_aud_tid,
    input  logic             en,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_sdata,
    output logic             underrun,
    output logic             sync_err,
    output logic [CNT_W-1:0] underrun_cnt
);

    localparam int              DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    typedef enum logic {
        EXPECT_LEFT  = 1'b0,
        EXPECT_RIGHT = 1'b1
    } chan_state_t;

    logic [DIV_W-1:0] div;
    logic [5:0]       pos;
    logic [63:0]      shift;
    logic [23:0]      left_smp;
    logic [23:0]      right_smp;
    logic             pair_full;
    logic             pair_full_next;
    chan_state_t      chan_state;

    logic             div_wrap;
    logic             bclk_fall;
    logic             frame_load;
    logic             accept;
    logic [5:0]       pos_inc;
    logic [23:0]      beat_smp;

    assign div_wrap   = en && (div == DIV_LAST);
    // The divider wraps while BCLK is high, so the toggle is a falling edge.
    assign bclk_fall  = div_wrap && i2s_bclk;
    assign pos_inc    = pos + 6'd1;
    // The frame is loaded on the falling edge that enters position 1.
    assign frame_load = bclk_fall && (pos_inc == 6'd1);
    assign accept     = s_axis_aud_tvalid && s_axis_aud_tready;
    assign beat_smp   = s_axis_aud_tdata[27:4];

    // Next pair-buffer state. A load and a completing beat never coincide,
    // because tready is low whenever the buffer is full.
    always_comb begin
        pair_full_next = pair_full;
        if (frame_load && pair_full) begin
            pair_full_next = 1'b0;
        end else if (accept && (chan_state == EXPECT_RIGHT) && (s_axis_aud_tid == 8'd1)) begin
            pair_full_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmit side: divider, frame position, shift register, underrun.
    // ------------------------------------------------------------------
    always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
        if (!s_axis_aud_aresetn) begin
            div          <= '0;
            i2s_bclk     <= 1'b0;
            i2s_lrclk    <= 1'b0;
            i2s_sdata    <= 1'b0;
            pos          <= 6'd63;
            shift        <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            if (!en) begin
                // Parking at position 63 makes the first falling edge
                // after re-enable land on position 0.
                div       <= '0;
                i2s_bclk  <= 1'b0;
                i2s_lrclk <= 1'b0;
                i2s_sdata <= 1'b0;
                pos       <= 6'd63;
                shift     <= '0;
            end else begin
                if (div_wrap) begin
                    div      <= '0;
                    i2s_bclk <= ~i2s_bclk;
                end else begin
                    div <= div + 1'b1;
                end

                if (bclk_fall) begin
                    pos       <= pos_inc;
                    i2s_lrclk <= pos_inc[5];
                    if (frame_load) begin
                        if (pair_full) begin
                            // The MSB goes out now. The rest of the frame is
                            // stored pre-shifted by one place.
                            i2s_sdata <= left_smp[23];
                            shift     <= {left_smp[22:0], 8'h00, right_smp, 8'h00, 1'b0};
                        end else begin
                            i2s_sdata <= 1'b0;
                            shift     <= '0;
                            underrun  <= 1'b1;
                            if (underrun_cnt != '1) begin
                                underrun_cnt <= underrun_cnt + 1'b1;
                            end
                        end
                    end else begin
                        i2s_sdata <= shift[63];
                        shift     <= {shift[62:0], 1'b0};
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stream side: left/right pairing, ready, sync errors.
    // ------------------------------------------------------------------
    always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
        if (!s_axis_aud_aresetn) begin
            s_axis_aud_tready <= 1'b0;
            pair_full         <= 1'b0;
            chan_state        <= EXPECT_LEFT;
            left_smp          <= '0;
            right_smp         <= '0;
            sync_err          <= 1'b0;
        end else begin
            sync_err  <= 1'b0;
            pair_full <= pair_full_next;
            // Ready is derived from the next buffer state. It therefore drops
            // on the same edge that completes a pair, and no extra beat slips
            // in.
            s_axis_aud_tready <= !pair_full_next;
            if (accept) begin
                case (chan_state)
                    EXPECT_LEFT: begin
                        if (s_axis_aud_tid == 8'd0) begin
                            left_smp   <= beat_smp;
                            chan_state <= EXPECT_RIGHT;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    EXPECT_RIGHT: begin
                        if (s_axis_aud_tid == 8'd1) begin
                            right_smp  <= beat_smp;
                            chan_state <= EXPECT_LEFT;
                        end else if (s_axis_aud_tid == 8'd0) begin
                            // A repeated left replaces the stored left.
                            left_smp <= beat_smp;
                            sync_err <= 1'b1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    default: chan_state <= EXPECT_LEFT;
                endcase
            end
        end
    end

endmodule

// File: doc/axis_i2s_tx.md
Name: axis_i2s_tx

Overview:
- Consumer end of the audio formatter MM2S AXI-Stream (32-bit tdata, channel-ID tid); serialises stereo samples onto a standard Philips I2S transmit port.
- Sits between the formatter's m_axis_mm2s output and the codec pins. All logic, including BCLK/LRCLK generation, runs in one clock domain.
- Pairs left/right beats into a frame buffer, reports underrun and channel-sync errors.

Parameters:
- BCLK_DIV, 4, clock cycles per BCLK half-period (>=1); BCLK = clk/(2*BCLK_DIV).
- CNT_W, 16, width of saturating underrun counter.

Ports:
- s_axis_aud_aclk  in  1  sole clock
- s_axis_aud_aresetn  in  1  reset, asynchronous, active-low
- s_axis_aud_tvalid  in  1  stream beat valid
- s_axis_aud_tready  out  1  stream ready
- s_axis_aud_tdata  in  32  sample word; audio sample in [27:4] (24-bit two's complement), other bits ignored
- s_axis_aud_tid  in  8  channel: 0 = left, 1 = right, others invalid
- en  in  1  transmit enable
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select (0 = left)
- i2s_sdata  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse: frame loaded with no complete pair
- sync_err  out  1  one-cycle pulse: unexpected tid accepted
- underrun_cnt  out  CNT_W  saturating underrun count

Behaviour:
- Reset: all outputs 0, s_axis_aud_tready 0 during reset and 1 the first cycle after; position counter p=63, divider 0, pair buffer empty, expect=LEFT.
- Divider: while en=1, div counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and toggles i2s_bclk. A 1->0 toggle is a falling edge: p <= p+1 mod 64 on that edge.
- en=0: synchronous stop. i2s_bclk, i2s_lrclk, i2s_sdata forced 0; div=0, p=63, shift register cleared. The pair buffer and stream side keep operating. On en rising, the first falling edge occurs 2*BCLK_DIV cycles later and enters p=0.
- Outputs update only on falling edges (registered), after entering position p:
  - i2s_lrclk = p[5] (0 for p in 0..31, 1 for p in 32..63).
  - i2s_sdata = bit 63-((p-1) mod 64) of 64-bit frame F = {Lslot, Rslot}; slot = {sample[23:0], 8'h00}.
  - Result: MSB lags the LRCLK edge by one BCLK. p=0 carries bit 0 of the previous frame's F.
- Frame load: on the falling edge entering p=1, F is loaded.
  - Pair buffer full: F = {L,R}; buffer cleared the same cycle.
  - Otherwise: F = 0, underrun pulses 1 cycle, underrun_cnt +1 saturating at all-ones. A partial pair (L only) is kept.
- Stream side:
  - s_axis_aud_tready = !pair_full (registered); a beat is accepted when tvalid&&tready.
  - expect=LEFT, tid=0: store L, expect=RIGHT.
  - expect=RIGHT, tid=1: store R, pair_full=1, expect=LEFT.
  - expect=RIGHT, tid=0: overwrite L, sync_err pulse, stay RIGHT.
  - expect=LEFT, tid!=0: discard, sync_err pulse.
  - expect=RIGHT, tid>1: discard, sync_err pulse, keep L.
- Simultaneous frame load and beat: not possible, since tready=0 while full. After a load, tready returns 1 the next cycle.
- Reset mid-frame: asynchronous return to reset state; a partial frame is dropped.

Test Plan:
- BCLK_DIV=2, en=1, feed L=0x00ABCDE0 (sample 0xABCDE), R=0x01234560 (tid 0,1) before first load -> bclk period 4 cycles, frame 256 cycles; lrclk low p0..31. Left bits are 0x0ABCDE00 MSB-first on p1..p31 plus p32; right bits are 0x12345600 on p33..p63 plus the next p0. No underrun.
- No stream data, en=1 -> sdata constantly 0; underrun pulse once per 64 BCLKs; underrun_cnt = 3 after three frames. With CNT_W=2, 5 frames -> counter saturates at 3.
- Beats tid 0,0,1 -> one sync_err pulse; frame transmits the second L value; third beat completes the pair.
- Beat tid=1 first, then tid=5 -> two sync_err pulses; both discarded, buffer empty, next load underruns.
- Continuous tvalid=1 with alternating tid -> tready drops after each pair, rises the cycle after each p=1 load; exactly one pair consumed per frame, no underrun.
- Deassert en mid-frame, then reassert; also pulse aresetn low mid-frame:
  - en=0: outputs 0 the next cycle; on re-enable, the first falling edge comes after 2*BCLK_DIV cycles at p=0.
  - aresetn low: outputs 0 immediately, tready 0 while in reset.
